// File: rtl/ip_tx_arbiter.sv
//==============================================================================
// Module   : ip_tx_arbiter
// Purpose  : Round-robin arbiter of the IP transmit path between UDP and ICMP,
//            with a registered byte forward and wait/data timeouts.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module ip_tx_arbiter #(
   parameter int TIMEOUT_W = 16,
   parameter int WAIT_MAX  = 1023
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ip_send_end,
   input  logic       udp_tx_req,
   input  logic       udp_tx_ready,
   input  logic [7:0] udp_tx_data,
   input  logic       udp_tx_end,
   output logic       udp_tx_ack,
   input  logic       icmp_tx_req,
   input  logic       icmp_tx_ready,
   input  logic [7:0] icmp_tx_data,
   input  logic       icmp_tx_end,
   output logic       icmp_tx_ack,
   input  logic       ip_tx_ack,
   output logic       ip_tx_req,
   output logic       ip_tx_ready,
   output logic [7:0] ip_tx_data,
   output logic       ip_tx_end,
   output logic [7:0] ip_tx_proto
);

   typedef enum logic [4:0] {
      S_IDLE      = 5'b00001,
      S_UDP_WAIT  = 5'b00010,
      S_UDP       = 5'b00100,
      S_ICMP_WAIT = 5'b01000,
      S_ICMP      = 5'b10000
   } state_t;

   localparam logic                 c_grant_udp  = 1'b0;
   localparam logic                 c_grant_icmp = 1'b1;
   localparam logic [TIMEOUT_W-1:0] c_wait_max   = TIMEOUT_W'(WAIT_MAX);
   localparam logic [7:0]           c_proto_udp  = 8'd17;
   localparam logic [7:0]           c_proto_icmp = 8'd1;

   state_t               r_state;
   state_t               w_next;
   logic [TIMEOUT_W-1:0] r_cnt;
   logic                 r_last_grant;
   logic                 w_wait_done;
   logic                 w_data_done;
   logic                 w_fwd_ready;
   logic [7:0]           w_fwd_data;
   logic                 w_fwd_end;

   assign w_wait_done = (r_cnt == c_wait_max);
   assign w_data_done = &r_cnt;

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (udp_tx_req && icmp_tx_req)
               w_next = (r_last_grant == c_grant_icmp) ? S_UDP_WAIT : S_ICMP_WAIT;
            else if (udp_tx_req)
               w_next = S_UDP_WAIT;
            else if (icmp_tx_req)
               w_next = S_ICMP_WAIT;
         end
         // ack takes priority over an expiring wait
         S_UDP_WAIT: begin
            if (ip_tx_ack)        w_next = S_UDP;
            else if (w_wait_done) w_next = S_IDLE;
         end
         S_ICMP_WAIT: begin
            if (ip_tx_ack)        w_next = S_ICMP;
            else if (w_wait_done) w_next = S_IDLE;
         end
         S_UDP, S_ICMP: begin
            if (ip_send_end || w_data_done) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_last_grant <= c_grant_icmp;
      end else begin
         r_state <= w_next;
         if (r_state == S_IDLE || w_next != r_state)
            r_cnt <= '0;
         else
            r_cnt <= r_cnt + 1'b1;
         // an abandoned wait still counts as that source's turn
         if (r_state == S_IDLE) begin
            if (w_next == S_UDP_WAIT)
               r_last_grant <= c_grant_udp;
            else if (w_next == S_ICMP_WAIT)
               r_last_grant <= c_grant_icmp;
         end
      end
   end

   always_comb begin
      w_fwd_ready = 1'b0;
      w_fwd_data  = 8'h00;
      w_fwd_end   = 1'b0;
      if (r_state == S_UDP) begin
         w_fwd_ready = udp_tx_ready;
         w_fwd_data  = udp_tx_data;
         w_fwd_end   = udp_tx_end;
      end else if (r_state == S_ICMP) begin
         w_fwd_ready = icmp_tx_ready;
         w_fwd_data  = icmp_tx_data;
         w_fwd_end   = icmp_tx_end;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ip_tx_req   <= 1'b0;
         udp_tx_ack  <= 1'b0;
         icmp_tx_ack <= 1'b0;
         ip_tx_ready <= 1'b0;
         ip_tx_data  <= 8'h00;
         ip_tx_end   <= 1'b0;
         ip_tx_proto <= 8'h00;
      end else begin
         ip_tx_req   <= (r_state == S_UDP_WAIT) || (r_state == S_ICMP_WAIT);
         udp_tx_ack  <= (r_state == S_UDP);
         icmp_tx_ack <= (r_state == S_ICMP);
         ip_tx_ready <= w_fwd_ready;
         ip_tx_data  <= w_fwd_data;
         ip_tx_end   <= w_fwd_end;
         if (r_state == S_UDP_WAIT || r_state == S_UDP)
            ip_tx_proto <= c_proto_udp;
         else if (r_state == S_ICMP_WAIT || r_state == S_ICMP)
            ip_tx_proto <= c_proto_icmp;
         else
            ip_tx_proto <= 8'h00;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_ip_tx_arbiter.sv
//==============================================================================
// Module   : tb_ip_tx_arbiter
// Purpose  : Self-checking bench for ip_tx_arbiter (phase/owner reference model).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_ip_tx_arbiter;

   localparam int TW         = 4;
   localparam int WM         = 7;
   localparam int DATA_LIMIT = (1 << TW) - 1;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ip_send_end = 1'b0;
   logic       udp_tx_req = 1'b0, udp_tx_ready = 1'b0, udp_tx_end = 1'b0;
   logic [7:0] udp_tx_data = 8'h00;
   logic       icmp_tx_req = 1'b0, icmp_tx_ready = 1'b0, icmp_tx_end = 1'b0;
   logic [7:0] icmp_tx_data = 8'h00;
   logic       ip_tx_ack = 1'b0;
   logic       udp_tx_ack, icmp_tx_ack, ip_tx_req, ip_tx_ready, ip_tx_end;
   logic [7:0] ip_tx_data, ip_tx_proto;
   logic [20:0] dut_vec;

   int total = 0;
   int bad   = 0;
   logic en_chk = 1'b0;

   ip_tx_arbiter #(.TIMEOUT_W(TW), .WAIT_MAX(WM)) dut (
      .clk(clk), .rst_n(rst_n), .ip_send_end(ip_send_end),
      .udp_tx_req(udp_tx_req), .udp_tx_ready(udp_tx_ready),
      .udp_tx_data(udp_tx_data), .udp_tx_end(udp_tx_end), .udp_tx_ack(udp_tx_ack),
      .icmp_tx_req(icmp_tx_req), .icmp_tx_ready(icmp_tx_ready),
      .icmp_tx_data(icmp_tx_data), .icmp_tx_end(icmp_tx_end), .icmp_tx_ack(icmp_tx_ack),
      .ip_tx_ack(ip_tx_ack), .ip_tx_req(ip_tx_req), .ip_tx_ready(ip_tx_ready),
      .ip_tx_data(ip_tx_data), .ip_tx_end(ip_tx_end), .ip_tx_proto(ip_tx_proto)
   );

   always #5 clk = ~clk;

   assign dut_vec = {ip_tx_req, udp_tx_ack, icmp_tx_ack, ip_tx_ready,
                     ip_tx_data, ip_tx_end, ip_tx_proto};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: who owns the path (1 UDP, 2 ICMP), which phase
   // (0 idle, 1 waiting for IP, 2 streaming) and how long it has dwelt there.
   int          m_phase = 0;
   int          m_owner = 0;
   int          m_last  = 2;
   int          m_dwell = 0;
   logic [20:0] m_exp   = '0;

   function automatic int pick_owner(input logic u, input logic i, input int last);
      if (u && i) return (last == 1) ? 2 : 1;
      return u ? 1 : 2;
   endfunction

   function automatic logic [9:0] source_bytes(input int phase, input int owner);
      if (phase != 2)  return 10'd0;
      if (owner == 1)  return {udp_tx_ready, udp_tx_data, udp_tx_end};
      return {icmp_tx_ready, icmp_tx_data, icmp_tx_end};
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_phase <= 0;
         m_owner <= 0;
         m_last  <= 2;
         m_dwell <= 0;
         m_exp   <= '0;
      end else begin
         m_exp <= {m_phase == 1, m_phase == 2 && m_owner == 1, m_phase == 2 && m_owner == 2,
                   source_bytes(m_phase, m_owner),
                   (m_phase == 0) ? 8'd0 : ((m_owner == 1) ? 8'd17 : 8'd1)};
         case (m_phase)
            0: if (udp_tx_req || icmp_tx_req) begin
                  m_owner <= pick_owner(udp_tx_req, icmp_tx_req, m_last);
                  m_last  <= pick_owner(udp_tx_req, icmp_tx_req, m_last);
                  m_phase <= 1;
                  m_dwell <= 0;
               end
            1: if (ip_tx_ack) begin
                  m_phase <= 2;
                  m_dwell <= 0;
               end else if (m_dwell == WM) m_phase <= 0;
               else m_dwell <= m_dwell + 1;
            2: if (ip_send_end || m_dwell == DATA_LIMIT) m_phase <= 0;
               else m_dwell <= m_dwell + 1;
            default: m_phase <= 0;
         endcase
      end
   end

   always @(negedge clk) begin
      if (en_chk) check("cycle_outputs", 32'(dut_vec), 32'(m_exp));
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      ip_send_end = 0; ip_tx_ack = 0;
      udp_tx_req = 0; udp_tx_ready = 0; udp_tx_data = 0; udp_tx_end = 0;
      icmp_tx_req = 0; icmp_tx_ready = 0; icmp_tx_data = 0; icmp_tx_end = 0;
   endtask

   task automatic do_reset();
      rst_n = 0;
      clear_inputs();
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1;
      en_chk = 1;
   endtask

   task automatic wait_grant(output int who);
      who = 0;
      for (int k = 0; k < 50 && who == 0; k++) begin
         tick();
         if (udp_tx_ack)       who = 1;
         else if (icmp_tx_ack) who = 2;
      end
   endtask

   task automatic end_pulse();
      ip_send_end = 1;
      tick();
      ip_send_end = 0;
   endtask

   initial begin
      int who, req_cnt, seen, cnt;
      logic done;
      logic [7:0] bytes [10];
      int exp_seq [4];

      // UDP-only frame
      do_reset();
      check("reset_outputs", 32'(dut_vec), 32'd0);
      for (int i = 0; i < 10; i++) bytes[i] = 8'($urandom);
      tick();
      udp_tx_req = 1;
      tick();
      req_cnt = 0;
      repeat (3) begin
         tick();
         if (ip_tx_req) req_cnt++;
      end
      ip_tx_ack = 1;
      tick();
      if (ip_tx_req) req_cnt++;
      check("ack_not_yet", 32'(udp_tx_ack), 32'd0);
      ip_tx_ack = 0;
      udp_tx_req = 0;
      for (int i = 0; i < 10; i++) begin
         udp_tx_ready = 1;
         udp_tx_data  = bytes[i];
         udp_tx_end   = (i == 9);
         tick();
         if (ip_tx_req) req_cnt++;
         check("udp_ack", 32'(udp_tx_ack), 32'd1);
         check("fwd_data", 32'(ip_tx_data), 32'(bytes[i]));
         check("fwd_end", 32'(ip_tx_end), (i == 9) ? 32'd1 : 32'd0);
         check("proto_udp", 32'(ip_tx_proto), 32'd17);
      end
      check("req_cycles", 32'(req_cnt), 32'd4);
      udp_tx_ready = 0; udp_tx_end = 0; udp_tx_data = 0;
      end_pulse();
      check("ack_after_end", 32'(udp_tx_ack), 32'd1);
      tick();
      check("idle_after_end", 32'(dut_vec), 32'd0);

      // Alternating grants under a permanent tie
      do_reset();
      exp_seq = '{1, 2, 1, 2};
      udp_tx_req = 1; icmp_tx_req = 1; ip_tx_ack = 1;
      for (int g = 0; g < 4; g++) begin
         wait_grant(who);
         check("tie_grant", 32'(who), 32'(exp_seq[g]));
         check("tie_proto", 32'(ip_tx_proto), (exp_seq[g] == 1) ? 32'd17 : 32'd1);
         end_pulse();
      end
      clear_inputs();
      tick();

      // ICMP wait abandoned, then a tie goes to UDP
      do_reset();
      tick();
      icmp_tx_req = 1;
      tick();
      icmp_tx_req = 0;
      req_cnt = 0;
      seen = 0;
      repeat (12) begin
         tick();
         if (ip_tx_req)   req_cnt++;
         if (icmp_tx_ack) seen++;
      end
      check("wait_abort_cycles", 32'(req_cnt), 32'd8);
      check("wait_abort_no_ack", 32'(seen), 32'd0);
      udp_tx_req = 1; icmp_tx_req = 1; ip_tx_ack = 1;
      wait_grant(who);
      check("tie_after_abort", 32'(who), 32'd1);
      clear_inputs();
      end_pulse();
      tick();

      // Data phase timeout
      do_reset();
      udp_tx_req = 1; ip_tx_ack = 1;
      wait_grant(who);
      check("timeout_grant", 32'(who), 32'd1);
      udp_tx_req = 0; ip_tx_ack = 0;
      cnt = 1;
      done = 0;
      for (int k = 0; k < 40 && !done; k++) begin
         tick();
         if (udp_tx_ack) cnt++;
         else            done = 1;
      end
      check("data_timeout_cycles", 32'(cnt), 32'd16);

      // ack arriving on the last wait cycle wins
      do_reset();
      tick();
      icmp_tx_req = 1;
      tick();
      icmp_tx_req = 0;
      repeat (7) tick();
      ip_tx_ack = 1;
      tick();
      ip_tx_ack = 0;
      tick();
      check("ack_at_wait_max", 32'(icmp_tx_ack), 32'd1);
      end_pulse();
      tick();

      // ack one cycle too late is ignored
      do_reset();
      tick();
      icmp_tx_req = 1;
      tick();
      icmp_tx_req = 0;
      repeat (8) tick();
      ip_tx_ack = 1;
      tick();
      ip_tx_ack = 0;
      tick();
      check("late_ack_ignored", 32'({icmp_tx_ack, ip_tx_req}), 32'd0);

      // Asynchronous reset mid-frame
      do_reset();
      udp_tx_req = 1; ip_tx_ack = 1;
      wait_grant(who);
      udp_tx_req = 0; ip_tx_ack = 0;
      udp_tx_ready = 1; udp_tx_data = 8'hA5;
      tick();
      tick();
      #2;
      rst_n = 0;
      #1;
      check("async_reset", 32'(dut_vec), 32'd0);
      clear_inputs();
      @(posedge clk);
      #3;
      rst_n = 1;
      udp_tx_req = 1; icmp_tx_req = 1; ip_tx_ack = 1;
      wait_grant(who);
      check("tie_after_reset", 32'(who), 32'd1);
      clear_inputs();
      end_pulse();
      tick();

      // Random traffic against the model
      do_reset();
      repeat (3000) begin
         udp_tx_req    = ($urandom_range(0, 9) < 3);
         icmp_tx_req   = ($urandom_range(0, 9) < 3);
         ip_tx_ack     = ($urandom_range(0, 3) == 0);
         ip_send_end   = ($urandom_range(0, 9) == 0);
         udp_tx_ready  = 1'($urandom);
         udp_tx_data   = 8'($urandom);
         udp_tx_end    = ($urandom_range(0, 4) == 0);
         icmp_tx_ready = 1'($urandom);
         icmp_tx_data  = 8'($urandom);
         icmp_tx_end   = ($urandom_range(0, 4) == 0);
         tick();
      end
      clear_inputs();
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/ip_tx_arbiter.md
# ip_tx_arbiter

Arbitrates the IP transmit path between the UDP and ICMP transmit engines. Each engine raises a request. The block grants one engine using round-robin, requests the IP layer, and forwards the granted engine's byte stream with one registered stage. It also presents the IP protocol number for the granted source and aborts stalled grants with timeouts.

## Interface

Parameters:
- TIMEOUT_W, 16: width of the shared cycle counter. A data phase aborts when the counter is all-ones.
- WAIT_MAX, 1023: cycles allowed in a WAIT state without ip_tx_ack before the grant is abandoned. Must be less than 2^TIMEOUT_W-1.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- ip_send_end  in  1  one-cycle pulse from the IP layer: current frame fully sent
- udp_tx_req  in  1  UDP engine requests transmission
- udp_tx_ready  in  1  UDP byte valid
- udp_tx_data  in  8  UDP byte
- udp_tx_end  in  1  UDP last byte
- udp_tx_ack  out  1  UDP granted, data phase active
- icmp_tx_req / icmp_tx_ready / icmp_tx_data[7:0] / icmp_tx_end  in: same meaning for ICMP
- icmp_tx_ack  out  1  ICMP granted, data phase active
- ip_tx_ack  in  1  IP layer accepts the pending request
- ip_tx_req  out  1  request to the IP layer
- ip_tx_ready  out  1  forwarded byte valid
- ip_tx_data  out  8  forwarded byte
- ip_tx_end  out  1  forwarded last byte
- ip_tx_proto  out  8  protocol number: 8'd17 UDP, 8'd1 ICMP, 8'd0 none

## Operation

State machine: IDLE, UDP_WAIT, UDP, ICMP_WAIT, ICMP. It uses a one-hot encoding, a registered state, and a combinational next-state.

Transitions:
- IDLE:
  - Only udp_tx_req set -> UDP_WAIT.
  - Only icmp_tx_req set -> ICMP_WAIT.
  - Both set -> the source not recorded in last_grant.
  - Neither set -> stay in IDLE.
- x_WAIT:
  - ip_tx_ack -> data state x.
  - Else counter == WAIT_MAX -> IDLE.
  - Else stay in x_WAIT.
  - ack wins over a simultaneous WAIT_MAX.
- Data state x:
  - ip_send_end -> IDLE.
  - Else counter all-ones -> IDLE.
  - Else stay in x.
- Illegal state -> IDLE.

Round-robin:
- last_grant is a 1-bit register. Reset value is ICMP, so UDP wins the first tie after reset.
- last_grant updates to x on leaving IDLE toward x_WAIT.
- An abandoned WAIT therefore still counts as a turn.

Counter:
- TIMEOUT_W bits.
- Cleared whenever next_state differs from state, and in IDLE.
- Increments in every WAIT or data cycle otherwise.
- Saturation is not needed, because exit happens at the limit.

A requester dropping req during its WAIT or data state is ignored. Exit is only via ack/ip_send_end or a timeout.

Registered outputs. Each updates on the clock edge after the state condition holds:
- ip_tx_req = 1 while state is UDP_WAIT or ICMP_WAIT.
- udp_tx_ack = 1 while state is UDP; icmp_tx_ack = 1 while state is ICMP.
- ip_tx_ready/data/end = the granted source's inputs while state is UDP or ICMP, otherwise 0/8'h00/0.
- ip_tx_proto = 17 in UDP_WAIT or UDP, 1 in ICMP_WAIT or ICMP, 0 otherwise.

All outputs reset to 0. State resets to IDLE, the counter to 0, and last_grant to ICMP. Reset mid-frame immediately zeroes all outputs. No state survives reset.

## Timing

- Request seen in IDLE at edge E0 -> x_WAIT after E0 -> ip_tx_req=1 after E1.
- ip_tx_ack sampled high at edge Ek -> data state after Ek.
  - Then ip_tx_req=0 and x_tx_ack=1 after Ek+1.
- Data latency: input sampled at edge n in the data state appears on ip_tx_* after edge n.
  - The visible delay is exactly one clock.
- ip_send_end at edge Em -> IDLE after Em -> ack and ip_tx_* zero after Em+1.
- IDLE lasts at least one cycle between grants.
- WAIT abort: the state leaves WAIT at the edge where the counter equals WAIT_MAX. The WAIT dwell is therefore WAIT_MAX+1 cycles.
- Data abort: IDLE after 2^TIMEOUT_W cycles in the data state.
- ip_send_end in a WAIT or IDLE state is ignored.

## Test plan

- UDP-only request, ip_tx_ack after 3 cycles, 10 bytes, then ip_send_end:
  - ip_tx_req is high for 4 cycles.
  - udp_tx_ack rises 1 cycle after ack is sampled.
  - ip_tx_data matches udp_tx_data delayed 1 cycle, with ip_tx_proto=17.
  - All outputs return to 0 two edges after ip_send_end.
- udp_tx_req and icmp_tx_req held continuously, with acks and ends returned promptly:
  - Grants alternate UDP, ICMP, UDP, ICMP, starting with UDP after reset.
  - ip_tx_proto alternates 17/1.
- ICMP request with no ip_tx_ack, WAIT_MAX=7:
  - IDLE after 8 WAIT cycles, and icmp_tx_ack is never asserted.
  - A subsequent tie grants UDP.
- Data phase with no ip_send_end, TIMEOUT_W=4:
  - IDLE after 16 data cycles, and ack drops.
- ip_tx_ack and counter==WAIT_MAX in the same cycle:
  - Enters the data state; ack wins.
- rst_n pulsed low mid-frame in the UDP state:
  - All outputs 0 asynchronously.
  - After release, a tie request grants UDP first.
